seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment digits, the parametrised successor to the single-digit hex-to-segment decoder. It holds a DIGITS-wide hex value, scans one digit per slot with anti-ghost blanking, and supports decimal points and leading-zero suppression. New values commit only at frame boundaries, so the display never tears. It sits between the datapath debug/status registers and the board display pins.

## Interface
- DIGITS, 4: number of digits, legal 1..8; index width IW = max(1, clog2(DIGITS)).
- DIVIDER, 50000: clk cycles per digit slot, legal >= 2.
- BLANK_CYCLES, 1: cycles at the start of each slot with all anodes off, legal 0..DIVIDER-1.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; when low, scanning freezes and anodes go inactive.
- load  in  1  one-cycle request to capture value/dp for display.
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- dp  in  DIGITS  decimal point request per digit, 1 = lit.
- lz_blank  in  1  leading-zero suppression enable; sampled live, not buffered.
- segments  out  7  {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- anodes_n  out  DIGITS  digit select, active low, at most one low at any time.
- frame  out  1  one-cycle pulse per completed scan frame.
- pending  out  1  high while a loaded value awaits commit.

## Operation
- Glyph encoding, active low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank=1111111.
- State: prescaler cnt (0..DIVIDER-1), digit index idx (0..DIGITS-1), pending buffer {pbuf, pdp}, pending flag, shadow {sval, sdp}.
- tick = enable && cnt==DIVIDER-1. On tick: cnt<=0, idx<=idx+1, with wrap DIGITS-1 -> 0 (wrap tick). Otherwise, when enable, cnt<=cnt+1. When enable is low, cnt and idx hold.
- load: pbuf<=value, pdp<=dp, pending<=1. A later load before commit overwrites the buffered value; the last load wins.
- Commit on wrap tick with pending: sval<=pbuf, sdp<=pdp, pending<=0.
- load coinciding with a wrap tick: the incoming value/dp go straight to the shadow and pending<=0.
- Leading-zero blank: digit i>0 is suppressed when lz_blank=1 and sval nibbles DIGITS-1..i are all zero. Digit 0 is never suppressed. A suppressed digit shows the blank glyph; its dp still follows sdp[i].

## Timing
- All outputs are registered and have 1-cycle latency from the (cnt, idx, shadow) state.
- anodes_n[i] is low iff enable && idx==i && cnt>=BLANK_CYCLES.
- segments shows the glyph of the selected digit (or blank); dp_n = ~sdp[idx]. Both are forced to all-ones whenever no anode is active.
- Slot = DIVIDER cycles; frame = DIGITS*DIVIDER cycles of enabled clock.
- frame is high for exactly the one cycle following each wrap tick.
- Reset (any time, including mid-frame or with pending set): cnt=0, idx=0, pending=0, pbuf/sval/sdp/pdp=0. Outputs: anodes_n all 1, segments=1111111, dp_n=1, frame=0, pending=0. After release, digit 0 is the first digit scanned.
- enable falling: anodes_n go all 1 on the next cycle. enable rising: resumes from the held cnt/idx.
- With DIGITS=1, every tick is a wrap tick.

## Test plan
- Reset/idle (DIGITS=4, DIVIDER=4, BLANK_CYCLES=1): assert reset mid-scan -> all outputs at reset values immediately; after release, anodes_n sequence 1111 then 1110 x3, 1111, 1101 x3, ...; frame pulses every 16 cycles.
- Load/commit: load value=16'h12AF, dp=4'b0100 mid-frame -> pending=1 until wrap; then digits 0..3 show 0001110, 0001000, 0100100 with dp_n=0, 1111001.
- Simultaneous events: load on the wrap-tick cycle -> pending stays 0 and the new value shows from digit 0. Two loads before wrap -> only the second value is displayed.
- Leading zeros: value=16'h0050, lz_blank=1 -> digits 3 and 2 blank, digit 1=0010010, digit 0=1000000. value=0 -> only digit 0 lit (1000000). With lz_blank=0 -> all four show 1000000.
- Enable gating: drop enable for 10 cycles mid-slot -> anodes_n=1111 and segments=1111111 from the next cycle, idx/cnt frozen; resume continues the same slot with the remaining cycle count.
- Sweep all 16 nibbles on digit 0 with DIGITS=1, BLANK_CYCLES=0 -> segments match the glyph table and anodes_n is constantly 0 after the first cycle.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed driver for DIGITS common-anode 7-segment
//             digits. Scans one digit per DIVIDER-cycle slot with a short
//             all-off blanking window at the start of each slot. It supports
//             decimal points and leading-zero suppression. Loaded values are
//             committed only at frame boundaries so a frame never tears.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int DIVIDER      = 50000,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp,
   input  logic                lz_blank,
   output logic [6:0]          segments,
   output logic                dp_n,
   output logic [DIGITS-1:0]   anodes_n,
   output logic                frame,
   output logic                pending
);

   localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int            CW       = $clog2(DIVIDER);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIVIDER - 1);

   // Scan position, pending buffer and committed shadow
   logic [CW-1:0]       cnt_q,  cnt_d;
   logic [IW-1:0]       idx_q,  idx_d;
   logic [4*DIGITS-1:0] pbuf_q, pbuf_d;
   logic [DIGITS-1:0]   pdp_q,  pdp_d;
   logic                pend_q, pend_d;
   logic [4*DIGITS-1:0] sval_q, sval_d;
   logic [DIGITS-1:0]   sdp_q,  sdp_d;

   // Registered pin-side outputs
   logic [6:0]          seg_q,   seg_d;
   logic                dpn_q,   dpn_d;
   logic [DIGITS-1:0]   an_q,    an_d;
   logic                frame_q, frame_d;

   logic                w_tick;
   logic                w_wrap;
   logic                w_past_blank;
   logic                w_lit;
   logic [DIGITS-1:0]   w_supp;
   logic [3:0]          w_sel_nib;
   logic                w_sel_dp;
   logic                w_sel_supp;

   // Active-low {g,f,e,d,c,b,a} glyph for one hex nibble
   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0011000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   assign w_tick = enable && (cnt_q == LAST_CNT);
   assign w_wrap = w_tick && (idx_q == LAST_IDX);

   // With no blanking window the digit is lit for the whole slot
   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_past_blank = 1'b1;
   end else begin : g_blank
      assign w_past_blank = (cnt_q >= CW'(BLANK_CYCLES));
   end

   assign w_lit = enable && w_past_blank;

   // Leading-zero mask: digit i is blank when every nibble from the top down to i is zero
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      w_supp   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero  = all_zero && (sval_q[4*i +: 4] == 4'h0);
         w_supp[i] = lz_blank && all_zero && (i != 0);
      end
   end

   // Pick the nibble, decimal point and suppression flag of the scanned digit
   always_comb begin
      w_sel_nib  = 4'h0;
      w_sel_dp   = 1'b0;
      w_sel_supp = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            w_sel_nib  = sval_q[4*i +: 4];
            w_sel_dp   = sdp_q[i];
            w_sel_supp = w_supp[i];
         end
      end
   end

   // Scan counters, load buffering and frame-boundary commit
   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      pbuf_d = pbuf_q;
      pdp_d  = pdp_q;
      pend_d = pend_q;
      sval_d = sval_q;
      sdp_d  = sdp_q;

      if (w_tick) begin
         cnt_d = '0;
         idx_d = w_wrap ? '0 : idx_q + 1'b1;
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (load) begin
         pbuf_d = value;
         pdp_d  = dp;
         pend_d = 1'b1;
      end

      // A load landing on the wrap tick bypasses the buffer entirely
      if (w_wrap) begin
         if (load) begin
            sval_d = value;
            sdp_d  = dp;
         end else if (pend_q) begin
            sval_d = pbuf_q;
            sdp_d  = pdp_q;
         end
         pend_d = 1'b0;
      end
   end

   // Output decode from the current scan state; forced dark when no anode is on
   always_comb begin
      seg_d   = 7'h7F;
      dpn_d   = 1'b1;
      an_d    = '1;
      frame_d = w_wrap;
      for (int i = 0; i < DIGITS; i++) begin
         an_d[i] = !(w_lit && (idx_q == IW'(i)));
      end
      if (w_lit) begin
         seg_d = w_sel_supp ? 7'h7F : hex_glyph(w_sel_nib);
         dpn_d = !w_sel_dp;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         pbuf_q  <= '0;
         pdp_q   <= '0;
         pend_q  <= 1'b0;
         sval_q  <= '0;
         sdp_q   <= '0;
         seg_q   <= 7'h7F;
         dpn_q   <= 1'b1;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pbuf_q  <= pbuf_d;
         pdp_q   <= pdp_d;
         pend_q  <= pend_d;
         sval_q  <= sval_d;
         sdp_q   <= sdp_d;
         seg_q   <= seg_d;
         dpn_q   <= dpn_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign segments = seg_q;
   assign dp_n     = dpn_q;
   assign anodes_n = an_q;
   assign frame    = frame_q;
   assign pending  = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver. A 4-digit instance is
//             tracked cycle by cycle against a position-arithmetic model;
//             a 1-digit instance sweeps every glyph.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

   localparam int D  = 4;
   localparam int V  = 4;
   localparam int B  = 1;
   localparam int FR = D * V;
   localparam int V1 = 3;

   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-digit instance
   logic        rst = 1'b0, en = 1'b0, ld = 1'b0, lz = 1'b0;
   logic [15:0] val = '0;
   logic [3:0]  dpi = '0;
   logic [6:0]  seg;
   logic        dpn, frm, pnd;
   logic [3:0]  an;

   // 1-digit instance
   logic        rst1 = 1'b0, ld1 = 1'b0;
   logic [3:0]  v1 = '0;
   logic [6:0]  seg1;
   logic        dpn1, frm1, pnd1;
   logic [0:0]  an1;

   seg7_scan_driver #(.DIGITS(D), .DIVIDER(V), .BLANK_CYCLES(B)) u4 (
      .clk(clk), .reset(rst), .enable(en), .load(ld), .value(val), .dp(dpi),
      .lz_blank(lz), .segments(seg), .dp_n(dpn), .anodes_n(an), .frame(frm),
      .pending(pnd));

   seg7_scan_driver #(.DIGITS(1), .DIVIDER(V1), .BLANK_CYCLES(0)) u1 (
      .clk(clk), .reset(rst1), .enable(1'b1), .load(ld1), .value(v1), .dp(1'b0),
      .lz_blank(1'b1), .segments(seg1), .dp_n(dpn1), .anodes_n(an1), .frame(frm1),
      .pending(pnd1));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // ---------------- reference model (4-digit instance) ----------------
   // Position within the frame is the number of enabled cycles modulo FR;
   // digit = pos / V, cycle-within-slot = pos % V.
   int          m_pos;
   logic [15:0] m_pbuf, m_sval;
   logic [3:0]  m_pdp, m_sdp;
   logic        m_pend;
   logic [6:0]  e_seg;
   logic [3:0]  e_an;
   logic        e_dpn, e_frm;
   logic        mdl_on = 1'b0;

   function automatic logic f_lit(int pos, logic e);
      return e && ((pos % V) >= B);
   endfunction

   function automatic logic [3:0] f_an(int pos, logic e);
      logic [3:0] a;
      a = 4'hF;
      if (f_lit(pos, e)) a[pos / V] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] f_seg(int pos, logic e, logic z, logic [15:0] sv);
      int         d;
      logic [3:0] nib;
      d   = pos / V;
      nib = 4'(sv >> (4 * d));
      if (!f_lit(pos, e)) return 7'h7F;
      if (z && d > 0 && (sv >> (4 * d)) == 16'd0) return 7'h7F;
      return GLYPH[nib];
   endfunction

   function automatic logic f_dpn(int pos, logic e, logic [3:0] sd);
      if (!f_lit(pos, e)) return 1'b1;
      return !sd[pos / V];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pos  <= 0;
         m_pbuf <= '0;
         m_pdp  <= '0;
         m_pend <= 1'b0;
         m_sval <= '0;
         m_sdp  <= '0;
         e_an   <= 4'hF;
         e_seg  <= 7'h7F;
         e_dpn  <= 1'b1;
         e_frm  <= 1'b0;
      end else begin
         e_an  <= f_an(m_pos, en);
         e_seg <= f_seg(m_pos, en, lz, m_sval);
         e_dpn <= f_dpn(m_pos, en, m_sdp);
         e_frm <= en && (m_pos == FR - 1);
         if (en && (m_pos == FR - 1)) begin
            m_pend <= 1'b0;
            if (ld) begin
               m_sval <= val;
               m_sdp  <= dpi;
            end else if (m_pend) begin
               m_sval <= m_pbuf;
               m_sdp  <= m_pdp;
            end
         end else if (ld) begin
            m_pend <= 1'b1;
         end
         if (ld) begin
            m_pbuf <= val;
            m_pdp  <= dpi;
         end
         if (en) m_pos <= (m_pos + 1) % FR;
      end
   end

   // Continuous comparison against the model
   always @(negedge clk) begin
      if (mdl_on) begin
         check("model_anodes", an, e_an);
         check("model_segments", seg, e_seg);
         check("model_dp_n", dpn, e_dpn);
         check("model_frame", frm, e_frm);
         check("model_pending", pnd, m_pend);
      end
   end

   // The single-digit instance must keep its anode on permanently
   logic u1_on = 1'b0;
   always @(negedge clk) begin
      if (u1_on) check("u1_anode_on", an1, 1'b0);
   end

   // ---------------- table vectors ----------------
   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  d;
      logic        z;
      logic [27:0] s;     // {d3,d2,d1,d0} glyphs
      logic [3:0]  dpn;   // {d3,d2,d1,d0}
   } vec_t;

   vec_t vt [7];

   logic [27:0] cap_s;
   logic [3:0]  cap_d;

   task automatic wait_frame();
      for (int k = 0; k < 64 && !frm; k++) tick();
      check("frame_wait", frm, 1'b1);
   endtask

   // Record what each digit shows during one full frame
   task automatic capture();
      cap_s = {28{1'bx}};
      cap_d = 4'bxxxx;
      for (int k = 0; k < FR; k++) begin
         tick();
         for (int j = 0; j < D; j++) begin
            if (an == ~(4'b0001 << j)) begin
               cap_s[7*j +: 7] = seg;
               cap_d[j]        = dpn;
            end
         end
      end
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      val = v;
      dpi = d;
      ld  = 1'b1;
      tick();
      ld  = 1'b0;
   endtask

   logic [3:0] an_exp_seq [16];
   logic [3:0] an_before;

   initial begin
      vt[0] = '{16'h12AF, 4'b0100, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1011};
      vt[1] = '{16'h0050, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
      vt[2] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
      vt[3] = '{16'h0000, 4'b0000, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
      vt[4] = '{16'h8000, 4'b1111, 1'b1, {7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0000};
      vt[5] = '{16'h0009, 4'b1000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0011000}, 4'b0111};
      vt[6] = '{16'h0B0D, 4'b0000, 1'b1, {7'b1111111, 7'b0000011, 7'b1000000, 7'b0100001}, 4'b1111};

      an_exp_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                     4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

      // Power-on reset
      #1;
      rst  = 1'b1;
      rst1 = 1'b1;
      #1;
      check("por_anodes", an, 4'hF);
      check("por_segments", seg, 7'h7F);
      tick();
      tick();
      rst    = 1'b0;
      rst1   = 1'b0;
      en     = 1'b1;
      mdl_on = 1'b1;
      tick();
      u1_on  = 1'b1;

      // Reset mid-scan with a load pending
      repeat (6) tick();
      pulse_load(16'hBEEF, 4'b1010);
      check("pending_after_load", pnd, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_anodes", an, 4'hF);
      check("rst_segments", seg, 7'h7F);
      check("rst_dp_n", dpn, 1'b1);
      check("rst_frame", frm, 1'b0);
      check("rst_pending", pnd, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < FR; k++) begin
         tick();
         check("post_rst_anodes", an, an_exp_seq[k]);
         check("post_rst_frame", frm, (k == FR - 1));
      end

      // Table vectors: load, wait for commit, inspect one full frame
      for (int i = 0; i < 7; i++) begin
         lz = vt[i].z;
         pulse_load(vt[i].v, vt[i].d);
         wait_frame();
         capture();
         check("vec_segments", cap_s, vt[i].s);
         check("vec_dp_n", cap_d, vt[i].dpn);
      end
      lz = 1'b0;

      // Two loads before the wrap: the second wins
      for (int k = 0; k < 40 && m_pos != 2; k++) tick();
      pulse_load(16'h1111, 4'b1111);
      tick();
      check("pending_between_loads", pnd, 1'b1);
      pulse_load(16'hC0DE, 4'b0001);
      wait_frame();
      capture();
      check("last_load_segments", cap_s, {7'b1000110, 7'b1000000, 7'b0100001, 7'b0000110});
      check("last_load_dp_n", cap_d, 4'b1110);

      // Load exactly on the wrap tick: straight to shadow, nothing pending
      for (int k = 0; k < 40 && m_pos != FR - 1; k++) tick();
      check("wrap_align", m_pos, FR - 1);
      pulse_load(16'h3456, 4'b0000);
      check("wrap_load_pending", pnd, 1'b0);
      check("wrap_load_frame", frm, 1'b1);
      capture();
      check("wrap_load_segments", cap_s, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});

      // Enable gating mid-slot
      for (int k = 0; k < 40 && (m_pos % V) != 2; k++) tick();
      an_before = an;
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("gated_anodes", an, 4'hF);
         check("gated_segments", seg, 7'h7F);
      end
      en = 1'b1;
      tick();
      check("resume_same_digit", an, an_before);

      // Randomised traffic against the model
      for (int k = 0; k < 3000; k++) begin
         en  = ($urandom_range(0, 9) != 0);
         ld  = ($urandom_range(0, 19) == 0);
         val = 16'($urandom);
         dpi = 4'($urandom);
         lz  = 1'($urandom);
         tick();
      end
      ld = 1'b0;
      en = 1'b1;

      // Single-digit glyph sweep
      for (int n = 0; n < 16; n++) begin
         v1  = 4'(n);
         ld1 = 1'b1;
         tick();
         ld1 = 1'b0;
         for (int k = 0; k < 16 && !frm1; k++) tick();
         check("u1_frame", frm1, 1'b1);
         tick();
         check("u1_glyph", seg1, GLYPH[n]);
         check("u1_dp_n", dpn1, 1'b1);
      end

      u1_on  = 1'b0;
      mdl_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
